// File: rtl/ninjin_image_mem_arbiter_if.sv
// Bus bundle between the image-memory arbiter, its two requesters
// (host AXI image slave and accelerator core) and the memory macro.
interface ninjin_image_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MEMSIZE    = 10
);
    logic                  host_req;
    logic                  host_lock;
    logic                  host_we;
    logic [MEMSIZE-1:0]    host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic                  host_gnt;
    logic                  host_rvalid;

    logic                  core_req;
    logic                  core_lock;
    logic                  core_we;
    logic [MEMSIZE-1:0]    core_addr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic                  core_gnt;
    logic                  core_rvalid;

    logic [DATA_WIDTH-1:0] rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [MEMSIZE-1:0]    mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Requester/memory environment view.
    modport master (
        output host_req, host_lock, host_we, host_addr, host_wdata,
        output core_req, core_lock, core_we, core_addr, core_wdata,
        output mem_rdata,
        input  host_gnt, host_rvalid, core_gnt, core_rvalid, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    // Arbiter view.
    modport slave (
        input  host_req, host_lock, host_we, host_addr, host_wdata,
        input  core_req, core_lock, core_we, core_addr, core_wdata,
        input  mem_rdata,
        output host_gnt, host_rvalid, core_gnt, core_rvalid, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ninjin_image_mem_arbiter.sv
// Single-port image buffer arbiter: host vs. accelerator core.
// One registered owner at a time, lock-aware bursts, fairness quantum,
// and a read-latency tracker that steers rvalid to the issuing side.
module ninjin_image_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MEMSIZE    = 10,
    parameter int RDLAT      = 1,
    parameter int QUANTUM    = 16
) (
    input logic                     clk,
    input logic                     xrst,
    ninjin_image_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOST, CORE} state_t;

    localparam logic [7:0] QMAX = 8'(QUANTUM);

    state_t                state;
    logic                  host_gnt;
    logic                  core_gnt;
    logic                  prio_core;
    logic [7:0]            qcnt;
    logic [7:0]            qnext;
    logic                  host_acc;
    logic                  core_acc;
    logic                  en_mux;
    logic                  we_mux;
    logic [MEMSIZE-1:0]    addr_mux;
    logic [DATA_WIDTH-1:0] wdata_mux;
    logic [RDLAT-1:0]      rd_vld;
    logic [RDLAT-1:0]      rd_core;

    // Memory-side mux and the saturating next value of the quantum counter.
    always_comb begin
        host_acc  = host_gnt && bus.host_req;
        core_acc  = core_gnt && bus.core_req;
        addr_mux  = core_gnt ? bus.core_addr  : bus.host_addr;
        wdata_mux = core_gnt ? bus.core_wdata : bus.host_wdata;
        en_mux    = host_acc || core_acc;
        we_mux    = host_acc ? bus.host_we : (core_acc && bus.core_we);
        qnext     = qcnt;
        if (en_mux && qcnt != QMAX) begin
            qnext = qcnt + 8'd1;
        end
    end

    // Ownership FSM with registered grants, round-robin pointer and quantum.
    // The quantum test uses the post-increment count so an owner gets at most
    // QUANTUM grant cycles before a waiting peer takes over on the same edge.
    always_ff @(posedge clk) begin
        if (xrst) begin
            state     <= IDLE;
            host_gnt  <= 1'b0;
            core_gnt  <= 1'b0;
            prio_core <= 1'b0;
            qcnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    qcnt <= '0;
                    if (bus.host_req && (!bus.core_req || !prio_core)) begin
                        state    <= HOST;
                        host_gnt <= 1'b1;
                    end else if (bus.core_req) begin
                        state    <= CORE;
                        core_gnt <= 1'b1;
                    end
                end
                HOST: begin
                    if (bus.host_lock) begin
                        qcnt <= qnext;
                    end else if (!bus.host_req || (qnext == QMAX && bus.core_req)) begin
                        prio_core <= 1'b1;
                        qcnt      <= '0;
                        host_gnt  <= 1'b0;
                        if (bus.core_req) begin
                            state    <= CORE;
                            core_gnt <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        qcnt <= qnext;
                    end
                end
                CORE: begin
                    if (bus.core_lock) begin
                        qcnt <= qnext;
                    end else if (!bus.core_req || (qnext == QMAX && bus.host_req)) begin
                        prio_core <= 1'b0;
                        qcnt      <= '0;
                        core_gnt  <= 1'b0;
                        if (bus.host_req) begin
                            state    <= HOST;
                            host_gnt <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        qcnt <= qnext;
                    end
                end
                default: begin
                    state    <= IDLE;
                    host_gnt <= 1'b0;
                    core_gnt <= 1'b0;
                    qcnt     <= '0;
                end
            endcase
        end
    end

    // Read-latency shift register of {valid, issued-by-core}.
    always_ff @(posedge clk) begin
        if (xrst) begin
            rd_vld  <= '0;
            rd_core <= '0;
        end else begin
            rd_vld[0]  <= en_mux && !we_mux;
            rd_core[0] <= core_gnt;
            for (int unsigned i = 1; i < RDLAT; i++) begin
                rd_vld[i]  <= rd_vld[i-1];
                rd_core[i] <= rd_core[i-1];
            end
        end
    end

    assign bus.host_gnt    = host_gnt;
    assign bus.core_gnt    = core_gnt;
    assign bus.mem_en      = en_mux;
    assign bus.mem_we      = we_mux;
    assign bus.mem_addr    = addr_mux;
    assign bus.mem_wdata   = wdata_mux;
    assign bus.host_rvalid = rd_vld[RDLAT-1] && !rd_core[RDLAT-1];
    assign bus.core_rvalid = rd_vld[RDLAT-1] &&  rd_core[RDLAT-1];
    assign bus.rdata       = bus.mem_rdata;
endmodule

// File: tb/tb_ninjin_image_mem_arbiter.sv
// Directed bench: three arbiters (RDLAT = 1, 2, 3) share one stimulus stream,
// each with its own behavioural memory.
module tb_ninjin_image_mem_arbiter;
    logic        clk = 1'b0;
    logic        xrst;
    logic        host_req, host_lock, host_we;
    logic [9:0]  host_addr;
    logic [31:0] host_wdata;
    logic        core_req, core_lock, core_we;
    logic [9:0]  core_addr;
    logic [31:0] core_wdata;

    logic [2:0]  hgnt, cgnt, hrv, crv, men, mwe;
    logic [9:0]  maddr [3];
    logic [31:0] mwd   [3];
    logic [31:0] rd    [3];

    int vectors;
    int miscompares;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = g + 1;

        ninjin_image_mem_arbiter_if #(.DATA_WIDTH(32), .MEMSIZE(10)) bus ();

        ninjin_image_mem_arbiter #(
            .DATA_WIDTH(32), .MEMSIZE(10), .RDLAT(LAT), .QUANTUM(16)
        ) dut (
            .clk (clk),
            .xrst(xrst),
            .bus (bus)
        );

        assign bus.host_req   = host_req;
        assign bus.host_lock  = host_lock;
        assign bus.host_we    = host_we;
        assign bus.host_addr  = host_addr;
        assign bus.host_wdata = host_wdata;
        assign bus.core_req   = core_req;
        assign bus.core_lock  = core_lock;
        assign bus.core_we    = core_we;
        assign bus.core_addr  = core_addr;
        assign bus.core_wdata = core_wdata;

        assign hgnt[g]  = bus.host_gnt;
        assign cgnt[g]  = bus.core_gnt;
        assign hrv[g]   = bus.host_rvalid;
        assign crv[g]   = bus.core_rvalid;
        assign men[g]   = bus.mem_en;
        assign mwe[g]   = bus.mem_we;
        assign maddr[g] = bus.mem_addr;
        assign mwd[g]   = bus.mem_wdata;
        assign rd[g]    = bus.rdata;

        logic [31:0] mem  [1024];
        logic [31:0] pipe [LAT];

        always_ff @(posedge clk) begin
            if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            pipe[0] <= mem[bus.mem_addr];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign bus.mem_rdata = pipe[LAT-1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit g set when a read accepted in cycles [a,b] returns in cycle k for RDLAT=g+1.
    function automatic logic [2:0] win(input int k, input int a, input int b);
        logic [2:0] m;
        m = '0;
        for (int g2 = 0; g2 < 3; g2++) begin
            if (k - (g2 + 1) >= a && k - (g2 + 1) <= b) m[g2] = 1'b1;
        end
        return m;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        host_req = 1'b0; host_lock = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        core_req = 1'b0; core_lock = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    endtask

    task automatic do_reset();
        next_cycle();
        xrst = 1'b1;
        clear_inputs();
        next_cycle();
        xrst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        xrst        = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_hgnt", hgnt, 3'b000);
        chk("rst_cgnt", cgnt, 3'b000);
        chk("rst_hrv",  hrv,  3'b000);
        chk("rst_crv",  crv,  3'b000);
        chk("rst_men",  men,  3'b000);
        chk("rst_mwe",  mwe,  3'b000);

        // Host alone: reads at 0..3.
        next_cycle();
        xrst = 1'b0;
        host_req = 1'b1;
        host_addr = 10'd0;
        @(negedge clk);
        chk("a0_hgnt", hgnt, 3'b000);
        chk("a0_men",  men,  3'b000);
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            if (k <= 4) host_addr = 10'(k - 1);
            else        host_req  = 1'b0;
            @(negedge clk);
            chk("a_hgnt", hgnt, (k <= 5) ? 3'b111 : 3'b000);
            chk("a_cgnt", cgnt, 3'b000);
            chk("a_men",  men,  (k <= 4) ? 3'b111 : 3'b000);
            if (k <= 4) chk("a_addr", maddr[0], 32'(k - 1));
            chk("a_hrv",  hrv,  win(k, 1, 4));
            chk("a_crv",  crv,  3'b000);
        end

        // Both request after reset: host first, quantum handover, reads tracked across it.
        do_reset();
        host_req = 1'b1; core_req = 1'b1;
        host_addr = 10'h020; core_addr = 10'h040;
        @(negedge clk);
        chk("b0_gnt", hgnt | cgnt, 3'b000);
        for (int k = 1; k <= 36; k++) begin
            next_cycle();
            if (k == 33) begin
                host_req = 1'b0;
                core_req = 1'b0;
            end
            @(negedge clk);
            chk("b_hgnt", hgnt, (k <= 16 || k == 33) ? 3'b111 : 3'b000);
            chk("b_cgnt", cgnt, (k >= 17 && k <= 32) ? 3'b111 : 3'b000);
            chk("b_men",  men,  (k <= 32) ? 3'b111 : 3'b000);
            chk("b_hrv",  hrv,  win(k, 1, 16));
            chk("b_crv",  crv,  win(k, 17, 32));
            if (k == 16) chk("b_addr_host", maddr[0], 32'h020);
            if (k == 17) chk("b_addr_core", maddr[0], 32'h040);
        end

        // Locked host burst of 40 writes with core waiting throughout.
        do_reset();
        host_req = 1'b1; host_lock = 1'b1; host_we = 1'b1; host_wdata = 32'h1234_0000;
        core_req = 1'b1; core_addr = 10'h100;
        @(negedge clk);
        chk("c0_gnt", hgnt | cgnt, 3'b000);
        for (int k = 1; k <= 42; k++) begin
            next_cycle();
            host_addr  = 10'(k);
            host_wdata = 32'h1234_0000 + 32'(k);
            if (k == 41) begin
                host_lock = 1'b0;
                host_req  = 1'b0;
            end
            @(negedge clk);
            chk("c_hgnt", hgnt, (k <= 41) ? 3'b111 : 3'b000);
            chk("c_cgnt", cgnt, (k == 42) ? 3'b111 : 3'b000);
            chk("c_mwe",  mwe,  (k <= 40) ? 3'b111 : 3'b000);
            chk("c_men",  men,  (k <= 40 || k == 42) ? 3'b111 : 3'b000);
            if (k == 40) chk("c_wdata", mwd[0], 32'h1234_0028);
        end

        // Core writes A5A5A5A5 to address 7, then host reads it back.
        do_reset();
        core_req = 1'b1; core_we = 1'b1; core_addr = 10'd7; core_wdata = 32'hA5A5_A5A5;
        host_addr = 10'd7; host_we = 1'b0;
        @(negedge clk);
        chk("d0_men", men, 3'b000);
        for (int k = 1; k <= 7; k++) begin
            next_cycle();
            if (k == 2) begin
                core_req = 1'b0;
                core_we  = 1'b0;
                host_req = 1'b1;
            end
            if (k == 4) host_req = 1'b0;
            @(negedge clk);
            if (k == 1) begin
                chk("d_cgnt",  cgnt,     3'b111);
                chk("d_wen",   men,      3'b111);
                chk("d_we",    mwe,      3'b111);
                chk("d_waddr", maddr[0], 32'd7);
                chk("d_wdata", mwd[0],   32'hA5A5_A5A5);
            end
            if (k == 2) chk("d_idle_en", men, 3'b000);
            if (k == 3) begin
                chk("d_hgnt",  hgnt,     3'b111);
                chk("d_ren",   men,      3'b111);
                chk("d_rwe",   mwe,      3'b000);
                chk("d_raddr", maddr[0], 32'd7);
            end
            chk("d_hrv", hrv, win(k, 3, 3));
            chk("d_crv", crv, 3'b000);
            for (int g = 0; g < 3; g++) begin
                if (k == 4 + g) chk("d_rdata", rd[g], 32'hA5A5_A5A5);
            end
        end

        // Reset one cycle after a host read: in-flight reads are dropped.
        next_cycle();
        host_req = 1'b1;
        host_addr = 10'd0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk("e1_hgnt", hgnt, 3'b111);
        chk("e1_men",  men,  3'b111);
        next_cycle();
        xrst = 1'b1;
        host_req = 1'b0;
        @(negedge clk);
        chk("e2_hrv",  hrv,  3'b001);
        chk("e2_hgnt", hgnt, 3'b111);
        for (int k = 3; k <= 7; k++) begin
            next_cycle();
            xrst = 1'b0;
            @(negedge clk);
            chk("e_hrv",  hrv,  3'b000);
            chk("e_crv",  crv,  3'b000);
            chk("e_hgnt", hgnt, 3'b000);
            chk("e_cgnt", cgnt, 3'b000);
            chk("e_men",  men,  3'b000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ninjin_image_mem_arbiter.md
Name: ninjin_image_mem_arbiter

Overview:
Shares the single-port image buffer between two requesters: the host side (the AXI image slave's memory port) and the accelerator core (image fetch and write-back).
- Grants one owner at a time. Holds the grant across locked bursts and enforces a fairness quantum.
- Tracks read latency so each requester receives only its own read data.
- Sits between the AXI image slave, the core datapath and the image memory macro.

Parameters:
DATA_WIDTH, 32, memory word width
MEMSIZE, 10, memory word-address width
RDLAT, 1, memory read latency in cycles (1..4)
QUANTUM, 16, maximum consecutive grant cycles before forced handover (2..255)

Ports:
clk  in  1  clock
xrst  in  1  reset; synchronous, active-high (asserted = 1), sampled on rising clk
host_req  in  1  host access request this cycle
host_lock  in  1  host burst in progress; no handover while high
host_we  in  1  host write enable
host_addr  in  MEMSIZE  host word address
host_wdata  in  DATA_WIDTH  host write data
host_gnt  out  1  host owns memory
host_rvalid  out  1  host read data valid
core_req  in  1  core access request
core_lock  in  1  core burst in progress
core_we  in  1  core write enable
core_addr  in  MEMSIZE  core word address
core_wdata  in  DATA_WIDTH  core write data
core_gnt  out  1  core owns memory
core_rvalid  out  1  core read data valid
rdata  out  DATA_WIDTH  read data, shared (mem_rdata passthrough)
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  MEMSIZE  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid RDLAT cycles after read strobe

Behaviour:
- FSM states: IDLE, HOST, CORE. host_gnt=1 only in HOST; core_gnt=1 only in CORE. Both grants are registered and never high together.
- Reset values: state IDLE, all outputs 0, priority pointer favours host, quantum counter 0, read pipeline cleared.
- IDLE transitions:
  - Only host_req -> HOST.
  - Only core_req -> CORE.
  - Both -> the side indicated by the pointer.
  - The grant appears the cycle after the request, so IDLE-to-grant latency is 1 cycle.
- Access acceptance: a requester's access is accepted when gnt && req in the same cycle.
  - On acceptance: mem_en=1; mem_we/addr/wdata are combinationally muxed from the owner.
  - Otherwise mem_en=0, mem_we=0; addr/wdata hold the owner's values.
  - A request without grant is ignored. The requester must hold it.
- Quantum counter: increments on each accepted owner cycle; clears on every state change; saturates at QUANTUM.
- Leaving owner state X (rules apply in this order):
  - X_lock=1 -> stay, regardless of quantum or the other side's request.
  - Else X_req=0 -> go to the other side if it requests, else IDLE.
  - Else counter reached QUANTUM and the other side requests -> go to the other side.
  - Else stay.
- Handover is direct (HOST->CORE or CORE->HOST) with no gap: the old grant drops and the new grant rises on the same edge.
- Pointer: on every handover or exit, the pointer points to the side not just served.
- Read tracking: RDLAT-stage shift register of {valid, owner}, loaded with {mem_en && !mem_we, owner} each cycle.
  - Stage RDLAT output drives host_rvalid or core_rvalid (exactly one, or none).
  - Pending reads complete even after a handover; the new owner may issue in the cycle of the handover.
- Lock asserted while the side is not granted has no effect until that side is granted.
- Reset asserted mid-operation: all state cleared next edge; in-flight reads are dropped with no rvalid.

Test Plan:
- Host alone, RDLAT=1: host_req=1, reads at addresses 0..3 -> host_gnt one cycle after the request; host_rvalid one cycle after each accepted read, 4 pulses; core_rvalid stays 0.
- Simultaneous first request after reset, both req=1, no lock -> HOST granted first (pointer); after 16 accepted cycles, direct handover to CORE; core_gnt rises as host_gnt falls.
- Locked host burst of 40 writes with core_req=1 throughout -> host keeps the grant all 40 cycles (quantum ignored); CORE granted on the cycle after host_lock falls.
- Handover with pending reads, RDLAT=3: host reads at cycles t, t+1, then handover -> host_rvalid at t+3 and t+4; core read at t+2 -> core_rvalid at t+5.
- Core writes 0xA5A5A5A5 to address 7, then host reads address 7 -> mem_we pulse with core data; host receives rdata=0xA5A5A5A5 with host_rvalid.
- xrst=1 asserted one cycle after a host read with RDLAT=2 -> no rvalid afterwards; state IDLE, all grants 0.
